// File: rtl/vga_frame_reader_pkg.sv
// -----------------------------------------------------------------------------
// vga_reader_pkg
// Shared definitions for the framebuffer read-back path.
//   - state_t          : frame reader FSM states
//   - DEF_* constants  : default framebuffer geometry
//   - LANES            : pixels packed into one framebuffer word
// No ports (package).
// -----------------------------------------------------------------------------
package vga_reader_pkg;

    localparam int          DEF_ADDR_WIDTH  = 17;
    localparam int          DEF_DATA_WIDTH  = 32;
    localparam int          DEF_PIXEL_WIDTH = 8;
    localparam logic [16:0] DEF_LAST_ADDR   = 17'h041EB;

    localparam int          LANES = DEF_DATA_WIDTH / DEF_PIXEL_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/vga_frame_reader_word_unpacker.sv
// -----------------------------------------------------------------------------
// word_unpacker
// Holds one framebuffer word and walks through its pixel lanes, least
// significant lane first.
//   clock     in   system clock, rising edge
//   resetn    in   synchronous active-low reset
//   load      in   capture word, restart at lane 0
//   word      in   framebuffer word to unpack
//   advance   in   current pixel consumed, step to the next lane
//   pixel     out  registered pixel of the current lane
//   last_lane out  current lane is the final lane of the word
// -----------------------------------------------------------------------------
module word_unpacker
    import vga_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int LANE_COUNT  = LANES
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   load,
    input  logic [DATA_WIDTH-1:0]  word,
    input  logic                   advance,
    output logic [PIXEL_WIDTH-1:0] pixel,
    output logic                   last_lane
);

    localparam int LANE_W = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1;

    logic [DATA_WIDTH-1:0] word_reg;
    logic [LANE_W-1:0]     lane;
    logic [LANE_W-1:0]     lane_inc;

    assign lane_inc  = lane + LANE_W'(1);
    assign last_lane = (lane == LANE_W'(LANE_COUNT - 1));

    // The pixel is kept in its own register (rather than muxed from word_reg)
    // so the stream output comes straight off a flop. On advance it is
    // preloaded with the lane that becomes current; after the last lane the
    // preloaded value is irrelevant because a new word is loaded first.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            word_reg <= '0;
            lane     <= '0;
            pixel    <= '0;
        end else if (load) begin
            word_reg <= word;
            lane     <= '0;
            pixel    <= word[PIXEL_WIDTH-1:0];
        end else if (advance) begin
            lane     <= lane_inc;
            pixel    <= word_reg[lane_inc*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
    end

endmodule

// File: rtl/vga_frame_reader.sv
// -----------------------------------------------------------------------------
// vga_frame_reader
// Reads a whole frame back out of the framebuffer, one word per read, and
// streams it as pixels (least significant byte of each word first).
//   clock        in   system clock, rising edge
//   resetn       in   synchronous active-low reset
//   start        in   pulse, begins a frame when idle
//   abort        in   level, drops the current frame immediately
//   busy         out  frame in progress
//   done         out  one-cycle pulse after the final pixel handshake
//   mem_address  out  framebuffer word address (held between reads)
//   mem_read     out  one-cycle read strobe per word
//   mem_readdata in   read data, valid one cycle after mem_read
//   pix_data     out  current pixel
//   pix_valid    out  pix_data valid
//   pix_ready    in   consumer accepts pix_data
// Build option: VGA_FRAME_READER_LOOP_EN - when defined, the reader wraps to
// address 0 after each frame and scans continuously until abort or reset.
// -----------------------------------------------------------------------------
module vga_frame_reader
    import vga_reader_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                    PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEF_LAST_ADDR)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic                   mem_read,
    input  logic [DATA_WIDTH-1:0]  mem_readdata,
    output logic [PIXEL_WIDTH-1:0] pix_data,
    output logic                   pix_valid,
    input  logic                   pix_ready
);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [ADDR_WIDTH-1:0] mem_address_next;
    logic                  mem_read_next;
    logic                  pix_valid_next;
    logic                  busy_next;
    logic                  done_next;

    logic                  handshake;
    logic                  load;
    logic                  advance;
    logic                  last_lane;

    // pix_valid mirrors the SHIFT state, so this is the stream handshake.
    assign handshake = pix_valid && pix_ready;

    // An abort squashes both a pending read return and a pending pixel step.
    assign load    = (state == WAIT) && !abort;
    assign advance = handshake && !abort;

    word_unpacker #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .LANE_COUNT  (DATA_WIDTH / PIXEL_WIDTH)
    ) u_unpacker (
        .clock     (clock),
        .resetn    (resetn),
        .load      (load),
        .word      (mem_readdata),
        .advance   (advance),
        .pixel     (pix_data),
        .last_lane (last_lane)
    );

    // State register plus all registered outputs. Outputs are derived from
    // the next state so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            addr        <= '0;
            mem_address <= '0;
            mem_read    <= 1'b0;
            pix_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            addr        <= addr_next;
            mem_address <= mem_address_next;
            mem_read    <= mem_read_next;
            pix_valid   <= pix_valid_next;
            busy        <= busy_next;
            done        <= done_next;
        end
    end

    // Next-state logic. Abort overrides every transition out of a non-idle
    // state; in IDLE it simply blocks a simultaneous start.
    always_comb begin
        state_next = state;
        addr_next  = addr;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    addr_next  = '0;
                    state_next = REQ;
                end
            end
            REQ:   state_next = WAIT;
            WAIT:  state_next = SHIFT;
            SHIFT: begin
                if (handshake && last_lane) begin
                    if (addr < LAST_ADDR) begin
                        addr_next  = addr + ADDR_WIDTH'(1);
                        state_next = REQ;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
`ifdef VGA_FRAME_READER_LOOP_EN
                addr_next  = '0;
                state_next = REQ;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase

        if (abort && (state != IDLE)) begin
            state_next = IDLE;
        end

        mem_read_next    = (state_next == REQ);
        mem_address_next = (state_next == REQ) ? addr_next : mem_address;
        pix_valid_next   = (state_next == SHIFT);
        busy_next        = (state_next != IDLE);
        done_next        = (state_next == DONE);
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_vga_frame_reader
// Self-checking bench for vga_frame_reader with a two-word frame
// (LAST_ADDR = 1). A behavioural model turns memory contents into the
// expected address list and pixel list; the bench consumes them as the DUT
// issues reads and completes handshakes. Inputs change on the falling edge,
// outputs are observed on the falling edge.
// Build option: VGA_FRAME_READER_LOOP_EN selects the continuous-scan checks.
// -----------------------------------------------------------------------------
module tb_vga_frame_reader;

    localparam int          NWORDS    = 2;
    localparam int          FRAME_PIX = NWORDS * 4;
    localparam logic [16:0] TB_LAST   = 17'd1;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [16:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_readdata;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;

    logic [31:0] mem [0:NWORDS-1];

    int          checks = 0;
    int          passes = 0;
    int          hs_count;
    int          done_count;
    logic        expect_done_next;
    logic        stall_prev;
    logic [7:0]  prev_data;
    logic [7:0]  exp_pix_q[$];
    logic [16:0] exp_addr_q[$];

    vga_frame_reader #(
        .ADDR_WIDTH  (17),
        .DATA_WIDTH  (32),
        .PIXEL_WIDTH (8),
        .LAST_ADDR   (TB_LAST)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_readdata (mem_readdata),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready)
    );

    always #5 clock = ~clock;

    // Memory returns data one cycle after the strobe and junk otherwise, so a
    // capture in the wrong cycle shows up as a wrong pixel.
    always @(posedge clock) begin
        if (mem_read && (mem_address < 17'(NWORDS)))
            mem_readdata <= mem[mem_address[0]];
        else
            mem_readdata <= $urandom();
    end

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected)
            passes++;
        else
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    endtask

    task clearModel();
        exp_pix_q.delete();
        exp_addr_q.delete();
        hs_count         = 0;
        done_count       = 0;
        expect_done_next = 1'b0;
        stall_prev       = 1'b0;
    endtask

    // Expected behaviour of whole frames: every word address in order, each
    // word split into bytes from least to most significant.
    task buildExpect(input int frames);
        logic [31:0] w;
        for (int f = 0; f < frames; f++) begin
            for (int a = 0; a < NWORDS; a++) begin
                exp_addr_q.push_back(17'(a));
                w = mem[a];
                for (int b = 0; b < 4; b++)
                    exp_pix_q.push_back(w[8*b +: 8]);
            end
        end
    endtask

    // Called at a falling edge once the inputs for the next rising edge are set.
    task observe();
        logic hs;
        if (mem_read) begin
            if (exp_addr_q.size() == 0)
                checkOutput("addr_extra", 32'(mem_read), 32'd0);
            else
                checkOutput("addr", 32'(mem_address), 32'(exp_addr_q.pop_front()));
        end
        if (stall_prev) begin
            checkOutput("hold_valid", 32'(pix_valid), 32'd1);
            checkOutput("hold_data", 32'(pix_data), 32'(prev_data));
        end
        if (done || expect_done_next)
            checkOutput("done", 32'(done), 32'(expect_done_next));
        if (done)
            done_count++;
        expect_done_next = 1'b0;
        hs = pix_valid && pix_ready && !abort;
        if (hs) begin
            if (exp_pix_q.size() == 0) begin
                checkOutput("pix_extra", 32'(pix_valid), 32'd0);
            end else begin
                checkOutput("pixel", 32'(pix_data), 32'(exp_pix_q.pop_front()));
                hs_count++;
                if (hs_count % FRAME_PIX == 0)
                    expect_done_next = 1'b1;
            end
        end
        stall_prev = pix_valid && !pix_ready && !abort;
        prev_data  = pix_data;
    endtask

    task applyStimulus(input logic s, input logic a, input logic r);
        start     = s;
        abort     = a;
        pix_ready = r;
        observe();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic rdy(input int mode, input int i);
        case (mode)
            0:       return 1'b1;
            1:       return (i % 2 == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Starts one frame and checks the start-to-pixel latency on the way.
    task beginFrame(input int frames, input int mode);
        clearModel();
        buildExpect(frames);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("busy_rise", 32'(busy), 32'd1);
        checkOutput("lat_read", 32'(mem_read), 32'd1);
        applyStimulus(1'b0, 1'b0, rdy(mode, 0));
        checkOutput("lat_wait", 32'(pix_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, rdy(mode, 1));
        checkOutput("lat_valid", 32'(pix_valid), 32'd1);
    endtask

    task runFrame(input int mode, input int start_at);
        beginFrame(1, mode);
        for (int i = 0; i < 200 && done_count == 0; i++)
            applyStimulus(i == start_at, 1'b0, rdy(mode, i));
        checkOutput("busy_fall", 32'(busy), 32'd0);
        checkOutput("pix_left", 32'(exp_pix_q.size()), 32'd0);
        checkOutput("addr_left", 32'(exp_addr_q.size()), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("done_count", 32'(done_count), 32'd1);
    endtask

    task runAbort();
        beginFrame(1, 0);
        for (int i = 0; i < 20 && hs_count < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_hs", 32'(hs_count), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        clearModel();
        checkOutput("abort_valid", 32'(pix_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_no_done", 32'(done_count), 32'd0);
    endtask

    task runMidReset();
        beginFrame(1, 0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
        start  = 1'b0;
        resetn = 1'b0;
        clearModel();
        @(posedge clock);
        @(negedge clock);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(pix_valid), 32'd0);
        checkOutput("rst_read", 32'(mem_read), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_addr", 32'(mem_address), 32'd0);
        resetn = 1'b1;
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst_no_done", 32'(done_count), 32'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b1;
        abort     = 1'b0;
        pix_ready = 1'b0;
        clearModel();
        repeat (3) @(negedge clock);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_read", 32'(mem_read), 32'd0);
        checkOutput("reset_valid", 32'(pix_valid), 32'd0);
        checkOutput("reset_addr", 32'(mem_address), 32'd0);
        resetn = 1'b1;
        start  = 1'b0;
        @(negedge clock);

        mem[0] = 32'h44332211;
        mem[1] = 32'h88776655;

`ifdef VGA_FRAME_READER_LOOP_EN
        beginFrame(2, 0);
        for (int i = 0; i < 200 && done_count < 2; i++) begin
            applyStimulus(i == 10, 1'b0, 1'b1);
            checkOutput("loop_busy", 32'(busy), 32'd1);
        end
        checkOutput("loop_done", 32'(done_count), 32'd2);
        checkOutput("loop_pix_left", 32'(exp_pix_q.size()), 32'd0);
        checkOutput("loop_addr_left", 32'(exp_addr_q.size()), 32'd0);
        // The reader has already wrapped into the third frame's first read.
        exp_addr_q.push_back(17'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        clearModel();
        checkOutput("loop_abort_busy", 32'(busy), 32'd0);
        checkOutput("loop_abort_valid", 32'(pix_valid), 32'd0);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("loop_abort_done", 32'(done_count), 32'd0);
`else
        runFrame(0, -1);
        runFrame(1, -1);
        runAbort();
        runFrame(0, -1);
        runFrame(0, 4);

        clearModel();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("start_abort_busy", 32'(busy), 32'd0);
        checkOutput("start_abort_read", 32'(mem_read), 32'd0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);

        repeat (4) begin
            mem[0] = $urandom();
            mem[1] = $urandom();
            runFrame(2, -1);
        end
        runMidReset();
`endif

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
